csr_issue_queue: RTL and testbench

- In-order issue queue for CSR, TLB, privileged and system micro-ops (csrrd/wr/xchg, tlb*, invtlb, cacop, ertn, idle, syscall, break).
- Sits directly upstream of the CSR execution unit, between dispatch and that unit.
- Holds up to DEPTH entries and tracks source-operand readiness from the writeback wakeup buses.
- Issues only the head entry, one at a time, and only when the CSR unit is idle (its CsrReq is low). This serialises privileged operations.

---
 rtl/csr_issue_queue_pkg.sv | 45 ++++
 rtl/csr_issue_queue_if.sv | 73 +++++++
 rtl/csr_issue_queue_wakeup_match.sv | 25 ++
 rtl/csr_issue_queue.sv | 171 +++++++++++++++++
 tb/tb_csr_issue_queue.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/csr_issue_queue_pkg.sv
// csr_issue_queue_pkg: shared types and constants for the in-order
// CSR / TLB / privileged micro-op issue queue.
package csr_issue_queue_pkg;

    localparam int CIQ_PREG_W = 7;
    localparam int CIQ_DATA_W = 32;
    localparam int WK_N       = 5;

    localparam logic [7:0] MOP_CSRRD   = 8'h01;
    localparam logic [7:0] MOP_CSRWR   = 8'h02;
    localparam logic [7:0] MOP_CSRXCHG = 8'h03;
    localparam logic [7:0] MOP_TLBSRCH = 8'h10;
    localparam logic [7:0] MOP_TLBRD   = 8'h11;
    localparam logic [7:0] MOP_TLBWR   = 8'h12;
    localparam logic [7:0] MOP_TLBFILL = 8'h13;
    localparam logic [7:0] MOP_INVTLB  = 8'h14;
    localparam logic [7:0] MOP_CACOP   = 8'h20;
    localparam logic [7:0] MOP_ERTN    = 8'h30;
    localparam logic [7:0] MOP_IDLE    = 8'h31;
    localparam logic [7:0] MOP_SYSCALL = 8'h32;
    localparam logic [7:0] MOP_BREAK   = 8'h33;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUED = 2'd1,
        S_WAIT   = 2'd2
    } ciq_state_e;

    typedef struct packed {
        logic [CIQ_DATA_W-1:0] pc;
        logic [7:0]            micop;
        logic                  src0_able;
        logic [CIQ_PREG_W-1:0] src0_num;
        logic                  src1_able;
        logic [CIQ_PREG_W-1:0] src1_num;
        logic                  rd_able;
        logic [CIQ_PREG_W-1:0] rd_addr;
        logic [13:0]           csr_num;
        logic [5:0]            rob_ptr;
        logic                  valid;
        logic                  rdy0;
        logic                  rdy1;
    } ciq_entry_t;

endpackage

// File: rtl/csr_issue_queue_if.sv
// csr_issue_queue_if: dispatch, wakeup, register-file and issue
// signals of the CSR issue queue; master drives, slave is the queue.
interface csr_issue_queue_if
    import csr_issue_queue_pkg::*;
#(
    parameter int PREG_W = CIQ_PREG_W,
    parameter int DATA_W = CIQ_DATA_W
) ();

    logic              IqStop;
    logic              IqFlash;
    logic              EnqValid;
    logic              EnqReady;
    logic [DATA_W-1:0] EnqPc;
    logic [7:0]        EnqMicOp;
    logic              EnqSrc0Able;
    logic [PREG_W-1:0] EnqSrc0Num;
    logic              EnqSrc0Rdy;
    logic              EnqSrc1Able;
    logic [PREG_W-1:0] EnqSrc1Num;
    logic              EnqSrc1Rdy;
    logic              EnqRdAble;
    logic [PREG_W-1:0] EnqRdAddr;
    logic [13:0]       EnqCsrNum;
    logic [5:0]        EnqRobPtr;
    logic [WK_N-1:0]   WkAble;
    logic [PREG_W-1:0] WkAddr [WK_N];
    logic [PREG_W-1:0] RfRd0Addr;
    logic [PREG_W-1:0] RfRd1Addr;
    logic [DATA_W-1:0] RfRd0Date;
    logic [DATA_W-1:0] RfRd1Date;
    logic              CsrBusy;
    logic              IssueAble;
    logic [DATA_W-1:0] IssuePc;
    logic [7:0]        IssueMicOp;
    logic              IssueSrc0Able;
    logic [PREG_W-1:0] IssueSrc0Num;
    logic [DATA_W-1:0] IssueSrc0Date;
    logic              IssueSrc1Able;
    logic [PREG_W-1:0] IssueSrc1Num;
    logic [DATA_W-1:0] IssueSrc1Date;
    logic              IssueRdAble;
    logic [PREG_W-1:0] IssueRdAddr;
    logic [13:0]       IssueCsrNum;
    logic [5:0]        IssueRobPtr;

    modport master (
        output IqStop, IqFlash, EnqValid, EnqPc, EnqMicOp,
        output EnqSrc0Able, EnqSrc0Num, EnqSrc0Rdy,
        output EnqSrc1Able, EnqSrc1Num, EnqSrc1Rdy,
        output EnqRdAble, EnqRdAddr, EnqCsrNum, EnqRobPtr,
        output WkAble, WkAddr, RfRd0Date, RfRd1Date, CsrBusy,
        input  EnqReady, RfRd0Addr, RfRd1Addr, IssueAble,
        input  IssuePc, IssueMicOp,
        input  IssueSrc0Able, IssueSrc0Num, IssueSrc0Date,
        input  IssueSrc1Able, IssueSrc1Num, IssueSrc1Date,
        input  IssueRdAble, IssueRdAddr, IssueCsrNum, IssueRobPtr
    );

    modport slave (
        input  IqStop, IqFlash, EnqValid, EnqPc, EnqMicOp,
        input  EnqSrc0Able, EnqSrc0Num, EnqSrc0Rdy,
        input  EnqSrc1Able, EnqSrc1Num, EnqSrc1Rdy,
        input  EnqRdAble, EnqRdAddr, EnqCsrNum, EnqRobPtr,
        input  WkAble, WkAddr, RfRd0Date, RfRd1Date, CsrBusy,
        output EnqReady, RfRd0Addr, RfRd1Addr, IssueAble,
        output IssuePc, IssueMicOp,
        output IssueSrc0Able, IssueSrc0Num, IssueSrc0Date,
        output IssueSrc1Able, IssueSrc1Num, IssueSrc1Date,
        output IssueRdAble, IssueRdAddr, IssueCsrNum, IssueRobPtr
    );

endinterface

// File: rtl/csr_issue_queue_wakeup_match.sv
// csr_iq_wakeup_match: flags a source register number that matches
// any active writeback wakeup bus this cycle.
module csr_iq_wakeup_match
    import csr_issue_queue_pkg::*;
#(
    parameter int PREG_W = CIQ_PREG_W
) (
    input  logic [PREG_W-1:0] i_num,
    input  logic [WK_N-1:0]   i_wk_able,
    input  logic [PREG_W-1:0] i_wk_addr [WK_N],
    output logic              o_hit
);

    logic [WK_N-1:0] w_eq;

    always_comb begin
        w_eq = '0;
        for (int i = 0; i < WK_N; i++) begin
            w_eq[i] = i_wk_able[i] && (i_wk_addr[i] == i_num);
        end
    end

    assign o_hit = |w_eq;

endmodule

// File: rtl/csr_issue_queue.sv
// csr_issue_queue: in-order serialising issue queue for CSR/TLB/system
// micro-ops. Define CSR_IQ_BYPASS_EN for same-cycle empty-queue issue.
module csr_issue_queue
    import csr_issue_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2,
    parameter int PREG_W = CIQ_PREG_W,
    parameter int DATA_W = CIQ_DATA_W
) (
    input logic              Clk,
    input logic              Rest,
    csr_issue_queue_if.slave bus
);

    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    ciq_entry_t       r_ent [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_cnt;
    ciq_state_e       r_state;

    logic [DEPTH-1:0] w_hit0;
    logic [DEPTH-1:0] w_hit1;
    logic             w_enq_hit0;
    logic             w_enq_hit1;
    logic             w_enq_rdy0;
    logic             w_enq_rdy1;
    logic             w_enq_fire;
    logic             w_head_go;
    logic             w_byp;
    logic             w_write;
    logic             w_issue;
    logic [DATA_W-1:0] w_iss_pc;
    ciq_entry_t       w_head;
    ciq_entry_t       w_enq_ent;

    for (genvar g = 0; g < DEPTH; g++) begin : g_wk
        csr_iq_wakeup_match #(.PREG_W(PREG_W)) u_wk0 (
            .i_num     (r_ent[g].src0_num),
            .i_wk_able (bus.WkAble),
            .i_wk_addr (bus.WkAddr),
            .o_hit     (w_hit0[g])
        );
        csr_iq_wakeup_match #(.PREG_W(PREG_W)) u_wk1 (
            .i_num     (r_ent[g].src1_num),
            .i_wk_able (bus.WkAble),
            .i_wk_addr (bus.WkAddr),
            .o_hit     (w_hit1[g])
        );
    end

    csr_iq_wakeup_match #(.PREG_W(PREG_W)) u_enq_wk0 (
        .i_num     (bus.EnqSrc0Num),
        .i_wk_able (bus.WkAble),
        .i_wk_addr (bus.WkAddr),
        .o_hit     (w_enq_hit0)
    );
    csr_iq_wakeup_match #(.PREG_W(PREG_W)) u_enq_wk1 (
        .i_num     (bus.EnqSrc1Num),
        .i_wk_able (bus.WkAble),
        .i_wk_addr (bus.WkAddr),
        .o_hit     (w_enq_hit1)
    );

    assign w_head     = r_ent[r_head];
    assign w_enq_rdy0 = bus.EnqSrc0Rdy | ~bus.EnqSrc0Able | w_enq_hit0;
    assign w_enq_rdy1 = bus.EnqSrc1Rdy | ~bus.EnqSrc1Able | w_enq_hit1;

    always_comb begin
        w_enq_ent           = '0;
        w_enq_ent.pc        = bus.EnqPc;
        w_enq_ent.micop     = bus.EnqMicOp;
        w_enq_ent.src0_able = bus.EnqSrc0Able;
        w_enq_ent.src0_num  = bus.EnqSrc0Num;
        w_enq_ent.src1_able = bus.EnqSrc1Able;
        w_enq_ent.src1_num  = bus.EnqSrc1Num;
        w_enq_ent.rd_able   = bus.EnqRdAble;
        w_enq_ent.rd_addr   = bus.EnqRdAddr;
        w_enq_ent.csr_num   = bus.EnqCsrNum;
        w_enq_ent.rob_ptr   = bus.EnqRobPtr;
        w_enq_ent.valid     = 1'b1;
        w_enq_ent.rdy0      = w_enq_rdy0;
        w_enq_ent.rdy1      = w_enq_rdy1;
    end

    // Slot availability ignores a same-cycle issue on purpose.
    assign bus.EnqReady = (r_cnt < CNT_FULL) & ~bus.IqStop
                        & ~bus.IqFlash & ~Rest;
    assign w_enq_fire   = bus.EnqValid & bus.EnqReady;

    assign w_head_go = w_head.valid & w_head.rdy0 & w_head.rdy1
                     & (r_state == S_IDLE) & ~bus.CsrBusy
                     & ~bus.IqStop & ~bus.IqFlash & ~Rest;

`ifdef CSR_IQ_BYPASS_EN
    assign w_byp = w_enq_fire & (r_cnt == '0) & (r_state == S_IDLE)
                 & ~bus.CsrBusy & w_enq_rdy0 & w_enq_rdy1;
`else
    assign w_byp = 1'b0;
`endif

    assign w_write = w_enq_fire & ~w_byp;
    assign w_issue = w_head_go | w_byp;

    assign w_iss_pc          = w_byp ? bus.EnqPc : w_head.pc;
    assign bus.IssueAble     = w_issue;
    assign bus.IssuePc       = w_iss_pc;
    assign bus.IssueMicOp    = w_byp ? bus.EnqMicOp : w_head.micop;
    assign bus.IssueSrc0Able = w_byp ? bus.EnqSrc0Able : w_head.src0_able;
    assign bus.IssueSrc1Able = w_byp ? bus.EnqSrc1Able : w_head.src1_able;
    assign bus.RfRd0Addr     = w_byp ? bus.EnqSrc0Num : w_head.src0_num;
    assign bus.RfRd1Addr     = w_byp ? bus.EnqSrc1Num : w_head.src1_num;
    assign bus.IssueSrc0Num  = bus.RfRd0Addr;
    assign bus.IssueSrc1Num  = bus.RfRd1Addr;
    assign bus.IssueSrc0Date = bus.RfRd0Date;
    assign bus.IssueSrc1Date = bus.RfRd1Date;
    assign bus.IssueRdAble   = w_byp ? bus.EnqRdAble : w_head.rd_able;
    assign bus.IssueRdAddr   = w_byp ? bus.EnqRdAddr : w_head.rd_addr;
    assign bus.IssueCsrNum   = w_byp ? bus.EnqCsrNum : w_head.csr_num;
    assign bus.IssueRobPtr   = w_byp ? bus.EnqRobPtr : w_head.rob_ptr;

    always_ff @(posedge Clk) begin
        if (Rest) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
            for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
        end else if (bus.IqFlash) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i].valid <= 1'b0;
                r_ent[i].rdy0  <= 1'b0;
                r_ent[i].rdy1  <= 1'b0;
            end
        end else if (!bus.IqStop) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_ent[i].valid) begin
                    if (w_hit0[i]) r_ent[i].rdy0 <= 1'b1;
                    if (w_hit1[i]) r_ent[i].rdy1 <= 1'b1;
                end
            end
            if (w_write) begin
                r_ent[r_tail] <= w_enq_ent;
                r_tail        <= r_tail + 1'b1;
            end
            if (w_head_go) begin
                r_ent[r_head].valid <= 1'b0;
                r_head              <= r_head + 1'b1;
            end
            unique case (1'b1)
                w_write && !w_head_go: r_cnt <= r_cnt + 1'b1;
                w_head_go && !w_write: r_cnt <= r_cnt - 1'b1;
                default: ;
            endcase
            // ISSUED covers the CSR unit's one-cycle CsrReq latency.
            unique case (r_state)
                S_IDLE:   if (w_issue) r_state <= S_ISSUED;
                S_ISSUED: r_state <= S_WAIT;
                S_WAIT:   if (!bus.CsrBusy) r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_issue_queue.sv
// tb_csr_issue_queue: directed self-checking bench for csr_issue_queue.
module tb_csr_issue_queue;
    import csr_issue_queue_pkg::*;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    csr_issue_queue_if bus ();

    csr_issue_queue dut (
        .Clk  (clk),
        .Rest (rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_in();
        bus.IqStop      = 1'b0;
        bus.IqFlash     = 1'b0;
        bus.EnqValid    = 1'b0;
        bus.EnqPc       = '0;
        bus.EnqMicOp    = '0;
        bus.EnqSrc0Able = 1'b0;
        bus.EnqSrc0Num  = '0;
        bus.EnqSrc0Rdy  = 1'b0;
        bus.EnqSrc1Able = 1'b0;
        bus.EnqSrc1Num  = '0;
        bus.EnqSrc1Rdy  = 1'b0;
        bus.EnqRdAble   = 1'b0;
        bus.EnqRdAddr   = '0;
        bus.EnqCsrNum   = '0;
        bus.EnqRobPtr   = '0;
        bus.WkAble      = '0;
        for (int i = 0; i < WK_N; i++) bus.WkAddr[i] = '0;
        bus.RfRd0Date   = '0;
        bus.RfRd1Date   = '0;
        bus.CsrBusy     = 1'b0;
    endtask

    task automatic set_enq(
        input logic [31:0] pc, input logic [7:0] mop,
        input logic a0, input logic [6:0] n0, input logic r0,
        input logic a1, input logic [6:0] n1, input logic r1,
        input logic [5:0] rob
    );
        bus.EnqValid    = 1'b1;
        bus.EnqPc       = pc;
        bus.EnqMicOp    = mop;
        bus.EnqSrc0Able = a0;
        bus.EnqSrc0Num  = n0;
        bus.EnqSrc0Rdy  = r0;
        bus.EnqSrc1Able = a1;
        bus.EnqSrc1Num  = n1;
        bus.EnqSrc1Rdy  = r1;
        bus.EnqRdAble   = 1'b1;
        bus.EnqRdAddr   = {1'b0, rob};
        bus.EnqCsrNum   = {8'h00, rob};
        bus.EnqRobPtr   = rob;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_in();
        rst = 1'b1;
        tick();
        settle();
        n_chk++;
        if (bus.EnqReady !== 1'b0) begin
            n_err++;
            $display("FAIL rst_enqready got %b exp 0", bus.EnqReady);
        end
        n_chk++;
        if (bus.IssueAble !== 1'b0) begin
            n_err++;
            $display("FAIL rst_issueable got %b exp 0", bus.IssueAble);
        end
        tick();
        rst = 1'b0;
        settle();
        n_chk++;
        if (bus.EnqReady !== 1'b1) begin
            n_err++;
            $display("FAIL post_rst_enqready got %b exp 1", bus.EnqReady);
        end
        n_chk++;
        if (bus.IssuePc !== 32'h0 || bus.IssueMicOp !== 8'h0) begin
            n_err++;
            $display("FAIL rst_payload got pc %h mop %h exp 0 0",
                     bus.IssuePc, bus.IssueMicOp);
        end
        n_chk++;
        if (dut.r_cnt !== 3'd0) begin
            n_err++;
            $display("FAIL rst_cnt got %0d exp 0", dut.r_cnt);
        end
    endtask

    task automatic test_basic_fsm();
        do_reset();
        set_enq(32'h1000, MOP_CSRRD, 1, 7'h05, 1, 1, 7'h06, 1, 6'd1);
        settle();
        n_chk++;
        if (bus.IssueAble !== 1'b0) begin
            n_err++;
            $display("FAIL basic_same_cyc got %b exp 0", bus.IssueAble);
        end
        tick();
        bus.EnqValid = 1'b0;
        settle();
        n_chk++;
        if (bus.IssueAble !== 1'b1 || bus.IssueMicOp !== MOP_CSRRD
            || bus.IssuePc !== 32'h1000) begin
            n_err++;
            $display("FAIL basic_issue got %b %h %h exp 1 %h 1000",
                     bus.IssueAble, bus.IssueMicOp, bus.IssuePc, MOP_CSRRD);
        end
        n_chk++;
        if (bus.RfRd0Addr !== 7'h05 || bus.RfRd1Addr !== 7'h06
            || bus.IssueCsrNum !== 14'h1 || bus.IssueRobPtr !== 6'd1) begin
            n_err++;
            $display("FAIL basic_fields got %h %h %h %h exp 05 06 1 1",
                     bus.RfRd0Addr, bus.RfRd1Addr,
                     bus.IssueCsrNum, bus.IssueRobPtr);
        end
        tick();
        n_chk++;
        if (dut.r_state !== S_ISSUED) begin
            n_err++;
            $display("FAIL basic_issued got %0d exp %0d",
                     dut.r_state, S_ISSUED);
        end
        bus.CsrBusy = 1'b1;
        set_enq(32'h1004, MOP_CSRXCHG, 1, 7'h07, 1, 1, 7'h08, 1, 6'd2);
        settle();
        n_chk++;
        if (bus.IssueAble !== 1'b0) begin
            n_err++;
            $display("FAIL basic_issued_able got %b exp 0", bus.IssueAble);
        end
        tick();
        bus.EnqValid = 1'b0;
        n_chk++;
        if (dut.r_state !== S_WAIT) begin
            n_err++;
            $display("FAIL basic_wait got %0d exp %0d", dut.r_state, S_WAIT);
        end
        tick();
        settle();
        n_chk++;
        if (bus.IssueAble !== 1'b0) begin
            n_err++;
            $display("FAIL basic_busy_able got %b exp 0", bus.IssueAble);
        end
        tick();
        bus.CsrBusy = 1'b0;
        settle();
        n_chk++;
        if (dut.r_state !== S_WAIT || bus.IssueAble !== 1'b0) begin
            n_err++;
            $display("FAIL basic_wait_exit got %0d %b exp %0d 0",
                     dut.r_state, bus.IssueAble, S_WAIT);
        end
        tick();
        settle();
        n_chk++;
        if (dut.r_state !== S_IDLE || bus.IssueAble !== 1'b1
            || bus.IssuePc !== 32'h1004) begin
            n_err++;
            $display("FAIL basic_reissue got %0d %b %h exp %0d 1 1004",
                     dut.r_state, bus.IssueAble, bus.IssuePc, S_IDLE);
        end
    endtask

    task automatic test_full();
        do_reset();
        bus.CsrBusy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_enq(32'h2000 + 32'(4 * k), MOP_TLBRD,
                    1, 7'h01, 1, 1, 7'h02, 1, 6'(k));
            settle();
            n_chk++;
            if (bus.EnqReady !== 1'b1) begin
                n_err++;
                $display("FAIL full_fill%0d got %b exp 1", k, bus.EnqReady);
            end
            tick();
        end
        set_enq(32'h2010, MOP_TLBWR, 1, 7'h01, 1, 1, 7'h02, 1, 6'd4);
        settle();
        n_chk++;
        if (bus.EnqReady !== 1'b0 || dut.r_cnt !== 3'd4
            || dut.r_tail !== 2'd0) begin
            n_err++;
            $display("FAIL full_state got %b %0d %0d exp 0 4 0",
                     bus.EnqReady, dut.r_cnt, dut.r_tail);
        end
        bus.CsrBusy = 1'b0;
        settle();
        n_chk++;
        if (bus.IssueAble !== 1'b1 || bus.IssuePc !== 32'h2000
            || bus.EnqReady !== 1'b0) begin
            n_err++;
            $display("FAIL full_issue got %b %h %b exp 1 2000 0",
                     bus.IssueAble, bus.IssuePc, bus.EnqReady);
        end
        tick();
        settle();
        n_chk++;
        if (dut.r_cnt !== 3'd3 || dut.r_head !== 2'd1
            || bus.EnqReady !== 1'b1) begin
            n_err++;
            $display("FAIL full_free got %0d %0d %b exp 3 1 1",
                     dut.r_cnt, dut.r_head, bus.EnqReady);
        end
        tick();
        bus.EnqValid = 1'b0;
        n_chk++;
        if (dut.r_cnt !== 3'd4 || dut.r_tail !== 2'd1) begin
            n_err++;
            $display("FAIL full_wrap got %0d %0d exp 4 1",
                     dut.r_cnt, dut.r_tail);
        end
    endtask

    task automatic test_wakeup();
        do_reset();
        set_enq(32'h3000, MOP_CSRWR, 1, 7'h01, 1, 1, 7'h23, 0, 6'd3);
        tick();
        bus.EnqValid  = 1'b0;
        bus.WkAble[3] = 1'b1;
        bus.WkAddr[3] = 7'h22;
        settle();
        n_chk++;
        if (bus.IssueAble !== 1'b0) begin
            n_err++;
            $display("FAIL wk_unready got %b exp 0", bus.IssueAble);
        end
        tick();
        bus.WkAddr[3] = 7'h23;
        settle();
        n_chk++;
        if (bus.IssueAble !== 1'b0) begin
            n_err++;
            $display("FAIL wk_nomatch got %b exp 0", bus.IssueAble);
        end
        tick();
        bus.WkAble    = '0;
        bus.RfRd0Date = 32'h12345678;
        bus.RfRd1Date = 32'hDEADBEEF;
        settle();
        n_chk++;
        if (bus.IssueAble !== 1'b1 || bus.RfRd1Addr !== 7'h23
            || bus.IssueSrc1Num !== 7'h23) begin
            n_err++;
            $display("FAIL wk_issue got %b %h %h exp 1 23 23",
                     bus.IssueAble, bus.RfRd1Addr, bus.IssueSrc1Num);
        end
        n_chk++;
        if (bus.IssueSrc1Date !== 32'hDEADBEEF
            || bus.IssueSrc0Date !== 32'h12345678) begin
            n_err++;
            $display("FAIL wk_data got %h %h exp 12345678 deadbeef",
                     bus.IssueSrc0Date, bus.IssueSrc1Date);
        end
    endtask

    task automatic test_enq_wakeup();
        do_reset();
        set_enq(32'h4000, MOP_CSRXCHG, 1, 7'h11, 0, 0, 7'h7f, 0, 6'd5);
        bus.WkAble[3] = 1'b1;
        bus.WkAddr[3] = 7'h11;
        settle();
        n_chk++;
        if (bus.IssueAble !== 1'b0) begin
            n_err++;
            $display("FAIL enqwk_same got %b exp 0", bus.IssueAble);
        end
        tick();
        bus.EnqValid = 1'b0;
        bus.WkAble   = '0;
        settle();
        n_chk++;
        if (bus.IssueAble !== 1'b1 || bus.IssuePc !== 32'h4000) begin
            n_err++;
            $display("FAIL enqwk_issue got %b %h exp 1 4000",
                     bus.IssueAble, bus.IssuePc);
        end
    endtask

    task automatic test_flash();
        do_reset();
        set_enq(32'h5000, MOP_TLBSRCH, 1, 7'h01, 1, 1, 7'h02, 1, 6'd6);
        tick();
        set_enq(32'h5004, MOP_INVTLB, 1, 7'h01, 1, 1, 7'h02, 1, 6'd7);
        settle();
        n_chk++;
        if (bus.IssueAble !== 1'b1 || bus.IssuePc !== 32'h5000) begin
            n_err++;
            $display("FAIL fl_issue got %b %h exp 1 5000",
                     bus.IssueAble, bus.IssuePc);
        end
        tick();
        n_chk++;
        if (dut.r_cnt !== 3'd1 || dut.r_tail !== 2'd2) begin
            n_err++;
            $display("FAIL fl_enq_iss got %0d %0d exp 1 2",
                     dut.r_cnt, dut.r_tail);
        end
        bus.CsrBusy = 1'b1;
        set_enq(32'h5008, MOP_CACOP, 1, 7'h01, 1, 1, 7'h02, 1, 6'd8);
        tick();
        set_enq(32'h500C, MOP_BREAK, 1, 7'h01, 1, 1, 7'h02, 1, 6'd9);
        tick();
        bus.EnqValid = 1'b0;
        n_chk++;
        if (dut.r_cnt !== 3'd3 || dut.r_state !== S_WAIT) begin
            n_err++;
            $display("FAIL fl_pre got %0d %0d exp 3 %0d",
                     dut.r_cnt, dut.r_state, S_WAIT);
        end
        bus.IqFlash = 1'b1;
        settle();
        n_chk++;
        if (bus.EnqReady !== 1'b0 || bus.IssueAble !== 1'b0) begin
            n_err++;
            $display("FAIL fl_during got %b %b exp 0 0",
                     bus.EnqReady, bus.IssueAble);
        end
        tick();
        bus.IqFlash = 1'b0;
        bus.CsrBusy = 1'b0;
        settle();
        n_chk++;
        if (dut.r_cnt !== 3'd0 || dut.r_state !== S_IDLE
            || bus.IssueAble !== 1'b0) begin
            n_err++;
            $display("FAIL fl_after got %0d %0d %b exp 0 %0d 0",
                     dut.r_cnt, dut.r_state, bus.IssueAble, S_IDLE);
        end
        set_enq(32'h5010, MOP_ERTN, 0, 7'h00, 0, 0, 7'h00, 0, 6'd10);
        tick();
        bus.EnqValid = 1'b0;
        settle();
        n_chk++;
        if (bus.IssueAble !== 1'b1 || bus.IssuePc !== 32'h5010
            || bus.IssueMicOp !== MOP_ERTN) begin
            n_err++;
            $display("FAIL fl_new got %b %h %h exp 1 5010 %h",
                     bus.IssueAble, bus.IssuePc, bus.IssueMicOp, MOP_ERTN);
        end
    endtask

    task automatic test_stop();
        do_reset();
        set_enq(32'h6000, MOP_IDLE, 0, 7'h00, 0, 0, 7'h00, 0, 6'd11);
        tick();
        bus.EnqValid = 1'b0;
        bus.IqStop   = 1'b1;
        settle();
        n_chk++;
        if (bus.IssueAble !== 1'b0 || bus.EnqReady !== 1'b0) begin
            n_err++;
            $display("FAIL stop_out got %b %b exp 0 0",
                     bus.IssueAble, bus.EnqReady);
        end
        tick();
        bus.IqStop = 1'b0;
        settle();
        n_chk++;
        if (dut.r_cnt !== 3'd1 || bus.IssueAble !== 1'b1) begin
            n_err++;
            $display("FAIL stop_hold got %0d %b exp 1 1",
                     dut.r_cnt, bus.IssueAble);
        end
    endtask

    task automatic test_bypass();
        do_reset();
        set_enq(32'h7000, MOP_SYSCALL, 0, 7'h00, 0, 0, 7'h00, 0, 6'd12);
        settle();
`ifdef CSR_IQ_BYPASS_EN
        n_chk++;
        if (bus.IssueAble !== 1'b1 || bus.IssueMicOp !== MOP_SYSCALL) begin
            n_err++;
            $display("FAIL byp_same got %b %h exp 1 %h",
                     bus.IssueAble, bus.IssueMicOp, MOP_SYSCALL);
        end
        tick();
        bus.EnqValid = 1'b0;
        n_chk++;
        if (dut.r_cnt !== 3'd0 || dut.r_state !== S_ISSUED) begin
            n_err++;
            $display("FAIL byp_after got %0d %0d exp 0 %0d",
                     dut.r_cnt, dut.r_state, S_ISSUED);
        end
`else
        n_chk++;
        if (bus.IssueAble !== 1'b0) begin
            n_err++;
            $display("FAIL nobyp_same got %b exp 0", bus.IssueAble);
        end
        tick();
        bus.EnqValid = 1'b0;
        settle();
        n_chk++;
        if (dut.r_cnt !== 3'd1 || bus.IssueAble !== 1'b1
            || bus.IssueMicOp !== MOP_SYSCALL) begin
            n_err++;
            $display("FAIL nobyp_next got %0d %b %h exp 1 1 %h",
                     dut.r_cnt, bus.IssueAble, bus.IssueMicOp, MOP_SYSCALL);
        end
`endif
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst   = 1'b1;
        clear_in();
        test_reset();
        test_basic_fsm();
        test_full();
        test_wakeup();
        test_enq_wakeup();
        test_flash();
        test_stop();
        test_bypass();
        tick();
        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
